// File: rtl/divider_if.sv
// rtl/divider_if.sv - request/result bundle between a divider client and the divider
interface divider_if;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - 6-bit by 3-bit restoring divider, one quotient bit per cycle, MSB first
module divider (
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] partial_q;
  logic [5:0] shift_q;
  logic [2:0] divisor_q;
  logic [2:0] cnt_q;
  logic       zero_q;

  logic [5:0] quotient_q;
  logic [2:0] remainder_q;
  logic       busy_q;
  logic       done_q;
  logic       div_by_zero_q;

  logic [3:0] shifted_d;
  logic [4:0] trial_d;
  logic       qbit_d;
  logic       unused_d;

  always_comb begin
    shifted_d = {partial_q[2:0], shift_q[5]};
    trial_d   = {1'b0, shifted_d} - {2'b00, divisor_q};
    qbit_d    = ~trial_d[4];
  end

  // partial_q[3] can never be set: every stored partial is below the divisor
  assign unused_d = partial_q[3];

  // Status and result outputs are registered one cycle behind the state they report.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      partial_q     <= 4'd0;
      shift_q       <= 6'd0;
      divisor_q     <= 3'd0;
      cnt_q         <= 3'd0;
      zero_q        <= 1'b0;
      quotient_q    <= 6'd0;
      remainder_q   <= 3'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      busy_q <= (state_q == CALC) || (state_q == DONE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            divisor_q <= bus.divisor;
            partial_q <= 4'd0;
            shift_q   <= bus.dividend;
            cnt_q     <= 3'd0;
            zero_q    <= (bus.divisor == 3'd0);
            state_q   <= (bus.divisor == 3'd0) ? DONE : CALC;
          end
        end
        CALC: begin
          partial_q <= qbit_d ? trial_d[3:0] : shifted_d;
          shift_q   <= {shift_q[4:0], qbit_d};
          cnt_q     <= cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          quotient_q    <= zero_q ? 6'h3F : shift_q;
          remainder_q   <= zero_q ? 3'd0 : partial_q[2:0];
          div_by_zero_q <= zero_q;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider against an arithmetic model
module tb_divider;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  divider_if dif ();

  divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quo"}, int'(dif.quotient), 0);
    check({tag, "_rem"}, int'(dif.remainder), 0);
    check({tag, "_dbz"}, int'(dif.div_by_zero), 0);
    check({tag, "_busy"}, int'(dif.busy), 0);
    check({tag, "_done"}, int'(dif.done), 0);
  endtask

  // One operation: pulse start, scramble operands (and optionally start) while in flight,
  // then watch 12 cycles for latency, busy profile, one done pulse and held results.
  task automatic run_op(input logic [5:0] a, input logic [2:0] b, input bit noise);
    int exp_q, exp_r, exp_z, exp_lat, done_cnt;
    exp_z   = (b == 3'd0) ? 1 : 0;
    exp_q   = exp_z ? 63 : int'(a) / int'(b);
    exp_r   = exp_z ? 0  : int'(a) % int'(b);
    exp_lat = exp_z ? 1 : 7;
    done_cnt = 0;

    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(negedge clk);
    dif.start    = noise ? 1'($urandom) : 1'b0;
    dif.dividend = 6'($urandom);
    dif.divisor  = 3'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("busy", int'(dif.busy), (k <= exp_lat) ? 1 : 0);
      check("done", int'(dif.done), (k == exp_lat) ? 1 : 0);
      if (dif.done) done_cnt++;
      if (k == exp_lat || k == 12) begin
        check("quo", int'(dif.quotient), exp_q);
        check("rem", int'(dif.remainder), exp_r);
        check("dbz", int'(dif.div_by_zero), exp_z);
      end
      dif.start    = (noise && k < exp_lat) ? 1'($urandom) : 1'b0;
      dif.dividend = 6'($urandom);
      dif.divisor  = 3'($urandom);
    end
    check("done_cnt", done_cnt, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    dif.start    = 1'b1;
    dif.dividend = 6'd45;
    dif.divisor  = 3'd6;

    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    rst_n     = 1'b1;
    dif.start = 1'b0;
    @(negedge clk);
    check_zero_outputs("post_rst");

    run_op(6'd45, 3'd6, 1'b0);
    run_op(6'd63, 3'd1, 1'b0);
    run_op(6'd5,  3'd7, 1'b0);
    run_op(6'd49, 3'd7, 1'b0);
    run_op(6'd20, 3'd0, 1'b0);
    run_op(6'd45, 3'd6, 1'b0);
    run_op(6'd0,  3'd3, 1'b0);

    // second start while busy must be ignored
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 6'd45; dif.divisor = 3'd6;
    @(negedge clk);
    dif.start = 1'b0; dif.dividend = 6'd11; dif.divisor = 3'd3;
    repeat (2) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 6'd10; dif.divisor = 3'd2;
    @(negedge clk);
    dif.start = 1'b0; dif.dividend = 6'd33; dif.divisor = 3'd5;
    begin
      int dn;
      dn = 0;
      for (int k = 4; k <= 14; k++) begin
        @(negedge clk);
        if (dif.done) dn++;
        if (k == 7) begin
          check("ovl_done", int'(dif.done), 1);
          check("ovl_quo", int'(dif.quotient), 7);
          check("ovl_rem", int'(dif.remainder), 3);
        end
      end
      check("ovl_done_cnt", dn, 1);
    end

    // reset in the middle of a calculation
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 6'd45; dif.divisor = 3'd6;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero_outputs("abort");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_done", int'(dif.done), 0);
      check("abort_busy", int'(dif.busy), 0);
    end
    run_op(6'd12, 3'd5, 1'b0);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_op(6'(a), 3'(b), 1'b1);
      end
    end

    for (int i = 0; i < 40; i++) begin
      run_op(6'($urandom), 3'($urandom), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
